byte_serial_add_ctrl: RTL and testbench

BYTE_SERIAL_ADD_CTRL -- requirements
Module: byte_serial_add_ctrl

---
 rtl/byte_serial_add_ctrl.sv | 106 ++++++++++
 tb/tb_byte_serial_add_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serial_add_ctrl.sv
// Multi-cycle WIDTH-bit adder that ripples one SLICE-bit slice per clock under a valid/ready handshake.
// Optional subtraction (sub port) is enabled by defining BYTE_SERIAL_ADD_SUB_EN.
module byte_serial_add_ctrl #(
  parameter int WIDTH = 64,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef BYTE_SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;

  logic [WIDTH-1:0] w_b_in;
  logic             w_cin_in;
  logic [31:0]      w_base;
  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic [SLICE:0]   w_slice_sum;

  // Subtraction is folded in at capture time: a - b == a + ~b + 1.
`ifdef BYTE_SERIAL_ADD_SUB_EN
  assign w_b_in   = sub ? ~b : b;
  assign w_cin_in = sub ? 1'b1 : cin;
`else
  assign w_b_in   = b;
  assign w_cin_in = cin;
`endif

  assign w_base      = 32'(r_cnt) * 32'(SLICE);
  assign w_a_slice   = r_a[w_base +: SLICE];
  assign w_b_slice   = r_b[w_base +: SLICE];
  assign w_slice_sum = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{SLICE{1'b0}}, r_carry};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_cin_in;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[w_base +: SLICE] <= w_slice_sum[SLICE-1:0];
          r_carry                <= w_slice_sum[SLICE];
          r_cnt                  <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_cout  <= w_slice_sum[SLICE];
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Self-checking bench for byte_serial_add_ctrl: directed corner cases plus randomized
// traffic compared against an arithmetic reference model.
module tb_byte_serial_add_ctrl;

  localparam int W = 64;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef BYTE_SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned edge_cnt = 0;

  byte_serial_add_ctrl #(.WIDTH(W), .SLICE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef BYTE_SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  // Reference: plain integer arithmetic; for subtraction cout means "no borrow" (a >= b).
  function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic ci, input logic s);
    logic [W:0] r;
    if (s) begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: v = '1;
      1: v = '0;
      2: v = v | 64'h00FF_FFFF_FFFF_FF00;
      default: ;
    endcase
    return v;
  endfunction

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sub(input logic s);
`ifdef BYTE_SERIAL_ADD_SUB_EN
    sub = s;
`else
    if (s) $display("[TB] note: subtraction requested without sub support");
`endif
  endtask

  // Issues one operation from IDLE with out_ready=1; returns result and edges from accept to out_valid.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s,
                        output logic [W-1:0] s_o, output logic c_o, output int lat);
    a = x; b = y; cin = ci; set_sub(s);
    in_valid = 1'b1; out_ready = 1'b1;
    wait_edge();
    in_valid = 1'b0;
    a = rand_op(); b = rand_op(); cin = 1'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      wait_edge();
      lat++;
    end
    s_o = sum;
    c_o = cout;
    wait_edge();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; set_sub(1'b0);
    repeat (2) wait_edge();
    n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (sum !== '0)         begin n_fail++; $display("FAIL reset_sum got=%h exp=0", sum); end
    n_tests++; if (cout !== 1'b0)      begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout); end
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_latency();
    a = 64'h1; b = 64'h2; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL first_accept_ready got=%b exp=1", in_ready); end
    wait_edge();
    in_valid = 1'b0; a = '1; b = '1; cin = 1'b1;
    for (int i = 1; i < N; i++) begin
      wait_edge();
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL run_flags T+%0d got ov=%b busy=%b ir=%b exp ov=0 busy=1 ir=0", i, out_valid, busy, in_ready);
      end
    end
    wait_edge();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_out_valid T+8 got=%b exp=1", out_valid); end
    n_tests++; if (sum !== 64'h3)      begin n_fail++; $display("FAIL basic_sum got=%h exp=3", sum); end
    n_tests++; if (cout !== 1'b0)      begin n_fail++; $display("FAIL basic_cout got=%b exp=0", cout); end
    wait_edge();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_T+9 got ir=%b ov=%b busy=%b exp ir=1 ov=0 busy=0", in_ready, out_valid, busy);
    end
    $display("[TB] test_latency 1+2 sum=%h cout=%b", sum, cout);
  endtask

  task automatic test_corners();
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic         vc [5];
    logic [W-1:0] x, y, s_o;
    logic         ci, c_o;
    logic [W:0]   exp_r;
    int           lat;
    va = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h00FF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    vb = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'h0, 64'h8000_0000_0000_0000};
    vc = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 25; i++) begin
      if (i < 5) begin
        x = va[i]; y = vb[i]; ci = vc[i];
      end else begin
        x = rand_op(); y = rand_op(); ci = 1'($urandom);
      end
      exp_r = ref_result(x, y, ci, 1'b0);
      run_op(x, y, ci, 1'b0, s_o, c_o, lat);
      n_tests++;
      if ({c_o, s_o} !== exp_r || lat != N) begin
        n_fail++;
        $display("FAIL add[%0d] a=%h b=%h cin=%b got cout=%b sum=%h lat=%0d exp cout=%b sum=%h lat=%0d",
                 i, x, y, ci, c_o, s_o, lat, exp_r[W], exp_r[W-1:0], N);
      end else begin
        $display("[TB] add[%0d] a=%h b=%h cin=%b -> cout=%b sum=%h", i, x, y, ci, c_o, s_o);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] x, y;
    logic [W:0]   exp_r;
    int           lat;
    x = rand_op(); y = rand_op();
    exp_r = ref_result(x, y, 1'b1, 1'b0);
    a = x; b = y; cin = 1'b1; set_sub(1'b0); in_valid = 1'b1; out_ready = 1'b0;
    wait_edge();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      wait_edge();
      lat++;
    end
    n_tests++; if (lat != N) begin n_fail++; $display("FAIL bp_latency got=%0d exp=%0d", lat, N); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom); a = rand_op(); b = rand_op(); cin = 1'($urandom);
      wait_edge();
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== exp_r) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got ov=%b ir=%b cout=%b sum=%h exp ov=1 ir=0 cout=%b sum=%h",
                 i, out_valid, in_ready, cout, sum, exp_r[W], exp_r[W-1:0]);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_edge();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got ir=%b ov=%b busy=%b exp ir=1 ov=0 busy=0", in_ready, out_valid, busy);
    end
    $display("[TB] test_backpressure held cout=%b sum=%h for 5 cycles", exp_r[W], exp_r[W-1:0]);
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] s_o;
    logic         c_o;
    int           lat;
    a = rand_op(); b = rand_op(); cin = 1'b1; set_sub(1'b0); in_valid = 1'b1; out_ready = 1'b1;
    wait_edge();
    in_valid = 1'b0;
    repeat (3) wait_edge();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async got ir=%b ov=%b busy=%b sum=%h cout=%b exp ir=1 ov=0 busy=0 sum=0 cout=0",
               in_ready, out_valid, busy, sum, cout);
    end
    wait_edge();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0) begin
      n_fail++;
      $display("FAIL abort_held got ir=%b ov=%b busy=%b sum=%h exp ir=1 ov=0 busy=0 sum=0",
               in_ready, out_valid, busy, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(64'h5, 64'h7, 1'b0, 1'b0, s_o, c_o, lat);
    n_tests++;
    if (s_o !== 64'hC || c_o !== 1'b0 || lat != N) begin
      n_fail++;
      $display("FAIL abort_recover got sum=%h cout=%b lat=%0d exp sum=c cout=0 lat=%0d", s_o, c_o, lat, N);
    end
    $display("[TB] test_reset_abort 5+7 -> sum=%h lat=%0d", s_o, lat);
  endtask

`ifdef BYTE_SERIAL_ADD_SUB_EN
  task automatic test_sub();
    logic [W-1:0] x, y, s_o;
    logic         ci, sb, c_o;
    logic [W:0]   exp_r;
    int           lat;
    for (int i = 0; i < 22; i++) begin
      if (i == 0) begin
        x = 64'h10; y = 64'h11; ci = 1'b0; sb = 1'b1;
      end else if (i == 1) begin
        x = 64'h11; y = 64'h10; ci = 1'b0; sb = 1'b1;
      end else begin
        x = rand_op(); y = rand_op(); ci = 1'($urandom); sb = 1'($urandom);
      end
      exp_r = ref_result(x, y, ci, sb);
      run_op(x, y, ci, sb, s_o, c_o, lat);
      n_tests++;
      if ({c_o, s_o} !== exp_r || lat != N) begin
        n_fail++;
        $display("FAIL sub[%0d] sub=%b a=%h b=%h got cout=%b sum=%h lat=%0d exp cout=%b sum=%h",
                 i, sb, x, y, c_o, s_o, lat, exp_r[W], exp_r[W-1:0]);
      end else begin
        $display("[TB] sub[%0d] sub=%b a=%h b=%h -> cout=%b sum=%h", i, sb, x, y, c_o, s_o);
      end
    end
  endtask
`endif

  // in_valid held high, operands re-randomized every cycle so post-accept changes are exercised too.
  task automatic test_back_to_back();
    logic [W:0]  exp_q[$];
    logic [W:0]  exp_r;
    logic        sb;
    int unsigned last_acc;
    bit          have_prev;
    int          n_done;
    int          cycles;
    have_prev = 1'b0; n_done = 0; cycles = 0; last_acc = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    while (n_done < 1000 && cycles < 12000) begin
      a = rand_op(); b = rand_op(); cin = 1'($urandom);
`ifdef BYTE_SERIAL_ADD_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      set_sub(sb);
      if (in_ready === 1'b1) begin
        if (have_prev) begin
          n_tests++;
          if (edge_cnt - last_acc != N + 1) begin
            n_fail++;
            $display("FAIL b2b_interval got=%0d exp=%0d", edge_cnt - last_acc, N + 1);
          end
        end
        exp_q.push_back(ref_result(a, b, cin, sb));
        last_acc  = edge_cnt + 1;
        have_prev = 1'b1;
      end
      if (out_valid === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_unexpected_result got cout=%b sum=%h exp none", cout, sum);
        end else begin
          exp_r = exp_q.pop_front();
          if ({cout, sum} !== exp_r) begin
            n_fail++;
            $display("FAIL b2b[%0d] got cout=%b sum=%h exp cout=%b sum=%h", n_done, cout, sum, exp_r[W], exp_r[W-1:0]);
          end else if (n_done % 100 == 0) begin
            $display("[TB] b2b[%0d] cout=%b sum=%h", n_done, cout, sum);
          end
        end
        n_done++;
      end
      wait_edge();
      cycles++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (n_done < 1000) begin
      n_fail++;
      $display("FAIL b2b_timeout got=%0d results exp=1000", n_done);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_corners();
    test_backpressure();
    test_reset_abort();
`ifdef BYTE_SERIAL_ADD_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
